dk_snd_ext_bus: RTL and testbench

External-bus controller for the Donkey Kong 8035 sound CPU. It sits directly on the T48 core's bus pins and performs the following functions:
- demultiplexes the ALE address;
- fetches program bytes from a synchronous ROM on PSEN;
- serves MOVX reads from a main-CPU command queue;
- drives the sound CPU's INTn from queue occupancy;
- emits strobed MOVX writes.

It replaces loose glue logic between the sound CPU wrapper, the sound ROM and the main-CPU command register.

---
 rtl/dk_snd_ext_bus.sv | 206 ++++++++++++++++++++
 tb/tb_dk_snd_ext_bus.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dk_snd_ext_bus.sv
// 8035 sound-CPU bus glue: ALE demux, PSEN ROM fetch, MOVX cmd-queue reads/writes, INTn. DK_SND_CMD_FIFO_EN selects 4-deep queue.
// Latency: ROM byte on O_DB 3 cycles after PSENn fall; all outputs registered; full queue drops pushes unless popped same cycle.
module dk_snd_ext_bus #(
  parameter int ROM_AW = 12
) (
  input  logic              I_CLK,
  input  logic              I_RST,
  input  logic              I_ALE,
  input  logic              I_PSENn,
  input  logic              I_RDn,
  input  logic              I_WRn,
  input  logic [7:0]        I_DB,
  input  logic [7:0]        I_P2,
  output logic [7:0]        O_DB,
  output logic              O_INTn,
  output logic [ROM_AW-1:0] O_ROM_A,
  output logic              O_ROM_RD,
  input  logic [7:0]        I_ROM_D,
  input  logic              I_CMD_WR,
  input  logic [7:0]        I_CMD,
  output logic              O_CMD_FULL,
  output logic              O_XWR_STB,
  output logic [7:0]        O_XWR_A,
  output logic [7:0]        O_XWR_D
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

  logic ale_d_q, psen_d_q, rd_d_q, wr_d_q;
  logic ale_fall, psen_fall, psen_rise, rd_rise, wr_rise;

  logic [7:0]  addr_lo_q;
  logic [3:0]  addr_hi_q;
  logic [11:0] fetch_addr;

  fetch_state_t      state_q, state_d;
  logic [7:0]        rom_q, rom_d;
  logic [ROM_AW-1:0] rom_a_q, rom_a_d;
  logic              rom_rd_q, rom_rd_d;

  logic [7:0] db_q, db_d;
  logic       intn_q;
  logic [7:0] wdata_q, xwr_a_q, xwr_d_q;
  logic       xwr_stb_q;

  logic       q_empty, q_pop, cmd_full;
  logic [7:0] q_head;

  wire unused_p2 = &{1'b0, I_P2[7:4]};

  assign ale_fall  = ale_d_q & ~I_ALE;
  assign psen_fall = psen_d_q & ~I_PSENn;
  assign psen_rise = ~psen_d_q & I_PSENn;
  assign rd_rise   = ~rd_d_q & I_RDn;
  assign wr_rise   = ~wr_d_q & I_WRn;

  assign fetch_addr = {addr_hi_q, addr_lo_q};
  assign q_pop      = rd_rise & ~addr_lo_q[0] & ~q_empty;

  // FETCH spends its first cycle with the read strobe out; data is taken on the second.
  always_comb begin
    state_d  = state_q;
    rom_d    = rom_q;
    rom_a_d  = rom_a_q;
    rom_rd_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (psen_fall) begin
          state_d  = S_FETCH;
          rom_a_d  = ROM_AW'(fetch_addr);
          rom_rd_d = 1'b1;
        end
      end
      S_FETCH: begin
        if (psen_rise) begin
          state_d = S_IDLE;
        end else if (!rom_rd_q) begin
          state_d = S_HOLD;
          rom_d   = I_ROM_D;
        end
      end
      S_HOLD: begin
        if (psen_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Mux looks at next-state fetch data so the ROM byte lands on O_DB the cycle HOLD begins.
  always_comb begin
    db_d = 8'hFF;
    if (!I_PSENn && state_d == S_HOLD) begin
      db_d = rom_d;
    end else if (!I_RDn && !addr_lo_q[0]) begin
      db_d = q_empty ? 8'hFF : q_head;
    end else if (!I_RDn) begin
      db_d = {7'b0, ~q_empty};
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      ale_d_q   <= 1'b0;
      psen_d_q  <= 1'b1;
      rd_d_q    <= 1'b1;
      wr_d_q    <= 1'b1;
      addr_lo_q <= 8'h00;
      addr_hi_q <= 4'h0;
      state_q   <= S_IDLE;
      rom_q     <= 8'h00;
      rom_a_q   <= '0;
      rom_rd_q  <= 1'b0;
      db_q      <= 8'hFF;
      intn_q    <= 1'b1;
      wdata_q   <= 8'h00;
      xwr_stb_q <= 1'b0;
      xwr_a_q   <= 8'h00;
      xwr_d_q   <= 8'h00;
    end else begin
      ale_d_q  <= I_ALE;
      psen_d_q <= I_PSENn;
      rd_d_q   <= I_RDn;
      wr_d_q   <= I_WRn;
      if (ale_fall) begin
        addr_lo_q <= I_DB;
        addr_hi_q <= I_P2[3:0];
      end
      state_q   <= state_d;
      rom_q     <= rom_d;
      rom_a_q   <= rom_a_d;
      rom_rd_q  <= rom_rd_d;
      db_q      <= db_d;
      intn_q    <= q_empty;
      if (!I_WRn) wdata_q <= I_DB;
      xwr_stb_q <= wr_rise;
      if (wr_rise) begin
        xwr_a_q <= addr_lo_q;
        xwr_d_q <= wdata_q;
      end
    end
  end

`ifdef DK_SND_CMD_FIFO_EN
  logic [7:0] mem_q [4];
  logic [1:0] wp_q, rp_q;
  logic [2:0] cnt_q, cnt_d;
  logic       push_ok;

  assign q_empty = (cnt_q == 3'd0);
  assign q_head  = mem_q[rp_q];
  // A pop in the same cycle frees the slot, so a push while full is still accepted.
  assign push_ok = I_CMD_WR & ((cnt_q != 3'd4) | q_pop);
  assign cnt_d   = cnt_q + {2'b0, push_ok} - {2'b0, q_pop};

  always_ff @(posedge I_CLK) begin
    if (push_ok) mem_q[wp_q] <= I_CMD;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      wp_q     <= 2'd0;
      rp_q     <= 2'd0;
      cnt_q    <= 3'd0;
      cmd_full <= 1'b0;
    end else begin
      if (push_ok) wp_q <= wp_q + 2'd1;
      if (q_pop)   rp_q <= rp_q + 2'd1;
      cnt_q    <= cnt_d;
      cmd_full <= (cnt_d == 3'd4);
    end
  end
`else
  logic [7:0] cmd_q;
  logic       cmd_vld_q;

  assign q_empty  = ~cmd_vld_q;
  assign q_head   = cmd_q;
  assign cmd_full = 1'b0;

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      cmd_q     <= 8'h00;
      cmd_vld_q <= 1'b0;
    end else if (I_CMD_WR) begin
      cmd_q     <= I_CMD;
      cmd_vld_q <= 1'b1;
    end else if (q_pop) begin
      cmd_vld_q <= 1'b0;
    end
  end
`endif

  assign O_DB       = db_q;
  assign O_INTn     = intn_q;
  assign O_ROM_A    = rom_a_q;
  assign O_ROM_RD   = rom_rd_q;
  assign O_CMD_FULL = cmd_full;
  assign O_XWR_STB  = xwr_stb_q;
  assign O_XWR_A    = xwr_a_q;
  assign O_XWR_D    = xwr_d_q;

endmodule

// File: tb/tb_dk_snd_ext_bus.sv
// Scoreboard bench for dk_snd_ext_bus: stimulus queues expected bus results, a negedge monitor retires them.
module tb_dk_snd_ext_bus;
  logic        I_CLK = 1'b0;
  logic        I_RST = 1'b1;
  logic        I_ALE = 1'b0, I_PSENn = 1'b1, I_RDn = 1'b1, I_WRn = 1'b1;
  logic [7:0]  I_DB = 8'h00, I_P2 = 8'h00, I_ROM_D = 8'h00, I_CMD = 8'h00;
  logic        I_CMD_WR = 1'b0;
  logic [7:0]  O_DB, O_XWR_A, O_XWR_D;
  logic [11:0] O_ROM_A;
  logic        O_INTn, O_ROM_RD, O_CMD_FULL, O_XWR_STB;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0]  rom_mem [4096];
  logic [11:0] exp_rom_a [$];
  logic [7:0]  exp_fetch [$];
  logic [7:0]  exp_db [$];
  logic [15:0] exp_xwr [$];

  dk_snd_ext_bus #(.ROM_AW(12)) dut (
    .I_CLK(I_CLK), .I_RST(I_RST), .I_ALE(I_ALE), .I_PSENn(I_PSENn),
    .I_RDn(I_RDn), .I_WRn(I_WRn), .I_DB(I_DB), .I_P2(I_P2),
    .O_DB(O_DB), .O_INTn(O_INTn), .O_ROM_A(O_ROM_A), .O_ROM_RD(O_ROM_RD),
    .I_ROM_D(I_ROM_D), .I_CMD_WR(I_CMD_WR), .I_CMD(I_CMD),
    .O_CMD_FULL(O_CMD_FULL), .O_XWR_STB(O_XWR_STB), .O_XWR_A(O_XWR_A),
    .O_XWR_D(O_XWR_D)
  );

  always #5 I_CLK = ~I_CLK;
  always @(posedge I_CLK) cyc++;

  // Synchronous ROM: data appears the cycle after the read strobe.
  always @(posedge I_CLK) if (O_ROM_RD) I_ROM_D <= rom_mem[O_ROM_A];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  logic psen_prev = 1'b1, rd_prev = 1'b1, wr_prev = 1'b1;
  int   psen_fall_cyc = -100, wr_rise_cyc = -100;

  always @(negedge I_CLK) begin
    logic [15:0] xw;
    if (!I_RST) begin
      if (psen_prev && !I_PSENn) psen_fall_cyc = cyc;
      if (!wr_prev && I_WRn) wr_rise_cyc = cyc;
      if (O_ROM_RD) begin
        if (exp_rom_a.size() == 0) chk("rom_rd_unexpected", 32'(O_ROM_RD), 0);
        else begin
          chk("rom_addr", 32'(O_ROM_A), 32'(exp_rom_a.pop_front()));
          chk("rom_rd_latency", 32'(cyc - psen_fall_cyc), 1);
        end
      end
      if (!I_PSENn && cyc == psen_fall_cyc + 3) begin
        if (exp_fetch.size() == 0) chk("fetch_unexpected", 32'(exp_fetch.size()), 1);
        else chk("fetch_db", 32'(O_DB), 32'(exp_fetch.pop_front()));
      end
      if (!rd_prev && I_RDn) begin
        if (exp_db.size() == 0) chk("read_unexpected", 32'(exp_db.size()), 1);
        else chk("movx_read_db", 32'(O_DB), 32'(exp_db.pop_front()));
      end
      if (O_XWR_STB) begin
        if (exp_xwr.size() == 0) chk("xwr_stb_unexpected", 32'(O_XWR_STB), 0);
        else begin
          xw = exp_xwr.pop_front();
          chk("xwr_addr", 32'(O_XWR_A), 32'(xw[15:8]));
          chk("xwr_data", 32'(O_XWR_D), 32'(xw[7:0]));
          chk("xwr_stb_latency", 32'(cyc - wr_rise_cyc), 1);
        end
      end
    end
    psen_prev = I_PSENn;
    rd_prev   = I_RDn;
    wr_prev   = I_WRn;
  end

  task automatic tick();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic ale(input logic [7:0] lo, input logic [7:0] p2);
    I_DB = lo; I_P2 = p2; I_ALE = 1'b1;
    tick();
    I_ALE = 1'b0;
    tick();
  endtask

  task automatic push(input logic [7:0] b);
    I_CMD = b; I_CMD_WR = 1'b1;
    tick();
    I_CMD_WR = 1'b0;
  endtask

  // Leaves the caller one cycle after the RDn rise; optional push lands on the rise cycle.
  task automatic movx_read(input logic [7:0] lo, input logic [7:0] exp,
                           input logic do_push, input logic [7:0] pb);
    exp_db.push_back(exp);
    ale(lo, 8'h00);
    I_RDn = 1'b0;
    tick();
    tick();
    I_RDn = 1'b1;
    if (do_push) begin I_CMD = pb; I_CMD_WR = 1'b1; end
    tick();
    I_CMD_WR = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_db"}, 32'(O_DB), 32'hFF);
    chk({tag, "_intn"}, 32'(O_INTn), 1);
    chk({tag, "_rom_a"}, 32'(O_ROM_A), 0);
    chk({tag, "_rom_rd"}, 32'(O_ROM_RD), 0);
    chk({tag, "_full"}, 32'(O_CMD_FULL), 0);
    chk({tag, "_xwr_stb"}, 32'(O_XWR_STB), 0);
    chk({tag, "_xwr_a"}, 32'(O_XWR_A), 0);
    chk({tag, "_xwr_d"}, 32'(O_XWR_D), 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'(i) ^ 8'h3C;
    rom_mem[12'h534] = 8'hA7;

    repeat (3) tick();
    chk_reset_outputs("reset");
    I_RST = 1'b0;
    tick();

    // Program fetch from 0x534
    ale(8'h34, 8'hF5);
    exp_rom_a.push_back(12'h534);
    exp_fetch.push_back(8'hA7);
    I_PSENn = 1'b0;
    repeat (5) tick();
    I_PSENn = 1'b1;
    tick();
    chk("db_after_psen", 32'(O_DB), 32'hFF);
    chk("rom_rd_idle", 32'(O_ROM_RD), 0);

`ifdef DK_SND_CMD_FIFO_EN
    push(8'h11); push(8'h22); push(8'h33);
    tick();
    chk("intn_after_push", 32'(O_INTn), 0);
    movx_read(8'h01, 8'h01, 1'b0, 8'h00);
    movx_read(8'h00, 8'h11, 1'b0, 8'h00);
    chk("intn_after_read1", 32'(O_INTn), 0);
    movx_read(8'h00, 8'h22, 1'b0, 8'h00);
    movx_read(8'h00, 8'h33, 1'b0, 8'h00);
    chk("intn_rise_plus1", 32'(O_INTn), 0);
    tick();
    chk("intn_rise_plus2", 32'(O_INTn), 1);

    push(8'hA1); push(8'hA2); push(8'hA3);
    chk("full_after_3", 32'(O_CMD_FULL), 0);
    push(8'hA4);
    chk("full_after_4", 32'(O_CMD_FULL), 1);
    push(8'hA5);
    chk("full_after_drop", 32'(O_CMD_FULL), 1);
    movx_read(8'h00, 8'hA1, 1'b1, 8'hB6);
    chk("full_push_pop", 32'(O_CMD_FULL), 1);
    movx_read(8'h00, 8'hA2, 1'b0, 8'h00);
    chk("full_after_pop", 32'(O_CMD_FULL), 0);
    movx_read(8'h00, 8'hA3, 1'b0, 8'h00);
    movx_read(8'h00, 8'hA4, 1'b0, 8'h00);
    movx_read(8'h00, 8'hB6, 1'b0, 8'h00);
    tick();
    chk("intn_fifo_drained", 32'(O_INTn), 1);
`else
    push(8'h11); push(8'h22);
    tick();
    chk("intn_after_push", 32'(O_INTn), 0);
    chk("full_tied_low", 32'(O_CMD_FULL), 0);
    movx_read(8'h01, 8'h01, 1'b0, 8'h00);
    movx_read(8'h00, 8'h22, 1'b0, 8'h00);
    chk("intn_rise_plus1", 32'(O_INTn), 0);
    tick();
    chk("intn_rise_plus2", 32'(O_INTn), 1);
`endif
    movx_read(8'h01, 8'h00, 1'b0, 8'h00);
    movx_read(8'h00, 8'hFF, 1'b0, 8'h00);

    // MOVX write
    ale(8'h80, 8'h00);
    exp_xwr.push_back({8'h80, 8'h5A});
    I_DB = 8'h5A; I_WRn = 1'b0;
    tick(); tick();
    I_WRn = 1'b1; I_DB = 8'hC3;
    repeat (3) tick();
    chk("xwr_a_hold", 32'(O_XWR_A), 32'h80);
    chk("xwr_d_hold", 32'(O_XWR_D), 32'h5A);
    chk("xwr_stb_low", 32'(O_XWR_STB), 0);

    // Reset during FETCH with RDn low and a queued command
    push(8'h77);
    ale(8'h00, 8'h00);
    I_PSENn = 1'b0; I_RDn = 1'b0;
    tick();
    I_RST = 1'b1;
    tick();
    chk_reset_outputs("midop_reset");
    I_PSENn = 1'b1; I_RDn = 1'b1;
    tick();
    I_RST = 1'b0;
    repeat (3) tick();
    chk("intn_after_midop", 32'(O_INTn), 1);
    movx_read(8'h01, 8'h00, 1'b0, 8'h00);

    repeat (4) tick();
    chk("leftover_rom", 32'(exp_rom_a.size()), 0);
    chk("leftover_fetch", 32'(exp_fetch.size()), 0);
    chk("leftover_db", 32'(exp_db.size()), 0);
    chk("leftover_xwr", 32'(exp_xwr.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
